// File: rtl/cmp_mem_subsys.sv
// Per-node instruction ROM / data RAM pair for the 4-node CMP, plus
// sticky "fetched end-of-program NOP" detection. Buses use big-endian
// numbering; node n owns slice [W*n : W*n+W-1].
module cmp_mem_subsys (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] pc_out,
  output logic [0:127] inst_in,
  input  logic [0:127] addr_out,
  input  logic [0:255] d_out,
  output logic [0:255] d_in,
  input  logic [0:3]   memEn,
  input  logic [0:3]   memWrEn,
  output logic [0:3]   node_done,
  output logic         any_done
);

  localparam int unsigned NODES      = 4;
  localparam int unsigned IW         = 32;
  localparam int unsigned DW         = 64;
  localparam int unsigned AW         = 8;
  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned DMEM_DEPTH = 256;

  // Storage: never cleared by reset, preloaded/dumped hierarchically.
  logic [0:IW-1] imem_mem_0 [0:IMEM_DEPTH-1];
  logic [0:IW-1] imem_mem_1 [0:IMEM_DEPTH-1];
  logic [0:IW-1] imem_mem_2 [0:IMEM_DEPTH-1];
  logic [0:IW-1] imem_mem_3 [0:IMEM_DEPTH-1];
  logic [0:DW-1] dmem_mem_0 [0:DMEM_DEPTH-1];
  logic [0:DW-1] dmem_mem_1 [0:DMEM_DEPTH-1];
  logic [0:DW-1] dmem_mem_2 [0:DMEM_DEPTH-1];
  logic [0:DW-1] dmem_mem_3 [0:DMEM_DEPTH-1];

  logic [AW-1:0] iidx  [NODES];
  logic [AW-1:0] didx  [NODES];
  logic [0:DW-1] wdata [NODES];
  logic [0:IW-1] inst  [NODES];
  logic [0:DW-1] rdata [NODES];
  logic          wr_en [NODES];

  logic [0:DW-1]    d_in_q [NODES];
  logic [0:DW-1]    d_in_d [NODES];
  logic [0:NODES-1] done_q;
  logic [0:NODES-1] done_d;

  // Per-node bus slicing; only word-address bits of pc/addr are used.
  for (genvar n = 0; n < NODES; n++) begin : g_node
    logic [0:IW-1] pc_s;
    logic [0:IW-1] addr_s;
    logic          unused_bits;

    assign pc_s        = pc_out[IW*n +: IW];
    assign addr_s      = addr_out[IW*n +: IW];
    assign iidx[n]     = pc_s[22:29];
    assign didx[n]     = addr_s[24:31];
    assign wdata[n]    = d_out[DW*n +: DW];
    assign wr_en[n]    = reset & memEn[n] & memWrEn[n];
    assign unused_bits = ^{pc_s[0:21], pc_s[30:31], addr_s[0:23]};

    assign inst_in[IW*n +: IW] = inst[n];
    assign d_in[DW*n +: DW]    = d_in_q[n];
  end

  // Zero-latency instruction fetch and RAM read ports.
  assign inst[0]  = imem_mem_0[iidx[0]];
  assign inst[1]  = imem_mem_1[iidx[1]];
  assign inst[2]  = imem_mem_2[iidx[2]];
  assign inst[3]  = imem_mem_3[iidx[3]];
  assign rdata[0] = dmem_mem_0[didx[0]];
  assign rdata[1] = dmem_mem_1[didx[1]];
  assign rdata[2] = dmem_mem_2[didx[2]];
  assign rdata[3] = dmem_mem_3[didx[3]];

  // RAM write ports; suppressed while reset is asserted at the edge.
  always_ff @(posedge clk) begin
    if (wr_en[0]) dmem_mem_0[didx[0]] <= wdata[0];
  end

  // Node 1 RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en[1]) dmem_mem_1[didx[1]] <= wdata[1];
  end

  // Node 2 RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en[2]) dmem_mem_2[didx[2]] <= wdata[2];
  end

  // Node 3 RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en[3]) dmem_mem_3[didx[3]] <= wdata[3];
  end

  // Next-state: load data holds unless a read is issued; done is sticky.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      d_in_d[n] = d_in_q[n];
      done_d[n] = done_q[n];
      if (memEn[n] && !memWrEn[n]) d_in_d[n] = rdata[n];
      if (inst[n] == '0)           done_d[n] = 1'b1;
    end
  end

  // Load-data and done-flag registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NODES; n++) d_in_q[n] <= '0;
      done_q <= '0;
    end else begin
      for (int n = 0; n < NODES; n++) d_in_q[n] <= d_in_d[n];
      done_q <= done_d;
    end
  end

  assign node_done = done_q;
  assign any_done  = |done_q;

endmodule

// File: tb/tb_cmp_mem_subsys.sv
// Scoreboard bench for cmp_mem_subsys: stimulus pushes expectations from a
// word-level memory model, a monitor pops and compares them.
module tb_cmp_mem_subsys;

  localparam int K_INST = 0;
  localparam int K_DIN  = 1;
  localparam int K_DONE = 2;
  localparam int K_ANY  = 3;
  localparam int K_MEM  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:127] pc_out, addr_out, inst_in;
  logic [0:255] d_out, d_in;
  logic [0:3]   memEn, memWrEn, node_done;
  logic         any_done;

  logic [31:0] pc_a [4];
  logic [31:0] addr_a [4];
  logic [63:0] wd_a [4];
  logic        en_a [4];
  logic        we_a [4];

  logic [31:0] ref_imem [4][256];
  logic [63:0] ref_dmem [4][256];
  logic [63:0] ref_din [4];
  logic        ref_done [4];

  typedef struct {
    int          kind;
    int          node;
    int          idx;
    logic [63:0] exp;
    longint      due;
  } chk_t;

  chk_t   q[$];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  event   mon_ev;

  always #5 clk = ~clk;

  cmp_mem_subsys dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .inst_in(inst_in),
    .addr_out(addr_out), .d_out(d_out), .d_in(d_in), .memEn(memEn),
    .memWrEn(memWrEn), .node_done(node_done), .any_done(any_done)
  );

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      pc_out[32*n +: 32]   = pc_a[n];
      addr_out[32*n +: 32] = addr_a[n];
      d_out[64*n +: 64]    = wd_a[n];
      memEn[n]             = en_a[n];
      memWrEn[n]           = we_a[n];
    end
  end

  function automatic logic [31:0] get_inst(int n);
    return inst_in[32*n +: 32];
  endfunction

  function automatic logic [63:0] get_din(int n);
    return d_in[64*n +: 64];
  endfunction

  function automatic logic [63:0] rd_dmem(int n, int i);
    case (n)
      0:       return dut.dmem_mem_0[i];
      1:       return dut.dmem_mem_1[i];
      2:       return dut.dmem_mem_2[i];
      default: return dut.dmem_mem_3[i];
    endcase
  endfunction

  function automatic string kname(int k);
    case (k)
      K_INST:  return "inst_in";
      K_DIN:   return "d_in";
      K_DONE:  return "node_done";
      K_ANY:   return "any_done";
      default: return "dmem";
    endcase
  endfunction

  task automatic pre_i(int n, int i, logic [31:0] v);
    ref_imem[n][i] = v;
    case (n)
      0:       dut.imem_mem_0[i] = v;
      1:       dut.imem_mem_1[i] = v;
      2:       dut.imem_mem_2[i] = v;
      default: dut.imem_mem_3[i] = v;
    endcase
  endtask

  task automatic pre_d(int n, int i, logic [63:0] v);
    ref_dmem[n][i] = v;
    case (n)
      0:       dut.dmem_mem_0[i] = v;
      1:       dut.dmem_mem_1[i] = v;
      2:       dut.dmem_mem_2[i] = v;
      default: dut.dmem_mem_3[i] = v;
    endcase
  endtask

  task automatic push(int kind, int node, int idx, logic [63:0] exp, longint due);
    chk_t c;
    c.kind = kind; c.node = node; c.idx = idx; c.exp = exp; c.due = due;
    q.push_back(c);
  endtask

  // Model: a byte PC selects word (pc/4) mod 256; data address is addr mod 256.
  function automatic logic [31:0] m_inst(int n);
    return ref_imem[n][int'((pc_a[n] >> 2) % 256)];
  endfunction

  function automatic int m_aidx(int n);
    return int'(addr_a[n] % 256);
  endfunction

  // Monitor: compare every expectation whose time has come.
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      while (q.size() > 0 && q[0].due <= cyc) begin
        chk_t        c;
        logic [63:0] act;
        c = q.pop_front();
        case (c.kind)
          K_INST:  act = {32'h0, get_inst(c.node)};
          K_DIN:   act = get_din(c.node);
          K_DONE:  act = 64'(node_done[c.node]);
          K_ANY:   act = 64'(any_done);
          default: act = rd_dmem(c.node, c.idx);
        endcase
        n_checks++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s node%0d idx%0d cyc%0d: got %h expected %h",
                   kname(c.kind), c.node, c.idx, cyc, act, c.exp);
        end
      end
    end
  end

  // One clock of stimulus: queue expectations, advance, update the model.
  task automatic step();
    logic [63:0] nd [4];
    logic        ndn [4];
    logic        any;
    for (int n = 0; n < 4; n++) push(K_INST, n, 0, {32'h0, m_inst(n)}, cyc);
    for (int n = 0; n < 4; n++) begin
      if (!reset) begin
        nd[n]  = '0;
        ndn[n] = 1'b0;
      end else begin
        nd[n]  = (en_a[n] && !we_a[n]) ? ref_dmem[n][m_aidx(n)] : ref_din[n];
        ndn[n] = ref_done[n] || (m_inst(n) == 32'h0);
      end
    end
    @(posedge clk);
    cyc++;
    any = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (reset && en_a[n] && we_a[n]) ref_dmem[n][m_aidx(n)] = wd_a[n];
      ref_din[n]  = nd[n];
      ref_done[n] = ndn[n];
      any         = any | ndn[n];
      push(K_DIN, n, 0, nd[n], cyc);
      push(K_DONE, n, 0, 64'(ndn[n]), cyc);
    end
    push(K_ANY, 0, 0, 64'(any), cyc);
    #1;
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 4; n++) begin
      pc_a[n] = '0; addr_a[n] = '0; wd_a[n] = '0; en_a[n] = 1'b0; we_a[n] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    for (int n = 0; n < 4; n++) begin
      ref_din[n]  = '0;
      ref_done[n] = 1'b0;
      for (int i = 0; i < 256; i++) begin
        pre_i(n, i, $urandom | 32'h1);
        pre_d(n, i, {$urandom, $urandom});
      end
    end
    #2;
    for (int n = 0; n < 4; n++) begin
      push(K_DIN, n, 0, 64'h0, cyc);
      push(K_DONE, n, 0, 64'h0, cyc);
    end
    push(K_ANY, 0, 0, 64'h0, cyc);
    -> mon_ev;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fetch from a preloaded word of node 2 only.
    pre_i(2, 5, 32'h8C220004);
    pc_a[2] = 32'h0000_0014;
    push(K_INST, 2, 0, 64'h8C220004, cyc);
    step();

    // Node 1 write then read-back.
    idle_inputs();
    en_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1] = 32'h10; wd_a[1] = 64'hDEADBEEF_01234567;
    step();
    we_a[1] = 1'b0;
    step();
    push(K_DIN, 1, 0, 64'hDEADBEEF_01234567, cyc);
    push(K_MEM, 1, 16, 64'hDEADBEEF_01234567, cyc);

    // Concurrent write on node 0 and read on node 3 of the same index.
    idle_inputs();
    pre_d(3, 0, 64'h1);
    en_a[0] = 1'b1; we_a[0] = 1'b1; wd_a[0] = '1;
    en_a[3] = 1'b1;
    step();
    push(K_DIN, 3, 0, 64'h1, cyc);
    push(K_MEM, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, cyc);

    // Upper address bits ignored on both ports.
    idle_inputs();
    en_a[2] = 1'b1; we_a[2] = 1'b1; addr_a[2] = 32'hABCD_0105; wd_a[2] = 64'h0123_4567_89AB_CDEF;
    pc_a[0] = 32'h0000_0400;
    push(K_INST, 0, 0, {32'h0, ref_imem[0][0]}, cyc);
    step();
    push(K_MEM, 2, 5, 64'h0123_4567_89AB_CDEF, cyc);

    // Random traffic, with a few NOPs seeded in the ROMs.
    for (int n = 0; n < 4; n++) pre_i(n, 200 + n, 32'h0);
    for (int k = 0; k < 300; k++) begin
      for (int n = 0; n < 4; n++) begin
        pc_a[n]   = $urandom;
        addr_a[n] = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
        wd_a[n]   = {$urandom, $urandom};
        en_a[n]   = 1'($urandom_range(0, 1));
        we_a[n]   = 1'($urandom_range(0, 1));
      end
      step();
    end

    // Asynchronous reset during an in-flight write aborts it.
    idle_inputs();
    pre_d(1, 16, 64'h5555_AAAA_5555_AAAA);
    en_a[1] = 1'b1; addr_a[1] = 32'h10;
    step();
    we_a[1] = 1'b1; wd_a[1] = 64'h1234;
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      ref_din[n]  = '0;
      ref_done[n] = 1'b0;
    end
    #1;
    for (int n = 0; n < 4; n++) begin
      push(K_DIN, n, 0, 64'h0, cyc);
      push(K_DONE, n, 0, 64'h0, cyc);
    end
    push(K_ANY, 0, 0, 64'h0, cyc);
    -> mon_ev;
    @(posedge clk);
    cyc++;
    #1;
    step();
    reset = 1'b1;
    idle_inputs();
    push(K_MEM, 1, 16, 64'h5555_AAAA_5555_AAAA, cyc);
    step();

    // Node 0 walks into a NOP at word 3.
    pre_i(0, 3, 32'h0);
    for (int p = 0; p < 5; p++) begin
      pc_a[0] = 32'(p * 4);
      step();
      if (p == 2) push(K_DONE, 0, 0, 64'h0, cyc);
      if (p >= 3) begin
        push(K_DONE, 0, 0, 64'h1, cyc);
        push(K_ANY, 0, 0, 64'h1, cyc);
      end
    end

    idle_inputs();
    step();
    step();
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
